// File: rtl/flash_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : flash_access_ctrl
//  Purpose  : Arbitrates the shared SPI configuration flash between the
//             internal FPGA flash master and the Raspberry Pi. Holds the
//             internal master off, inserts dead time around every Pi grant,
//             never cuts a Pi transaction in flight and revokes a silent Pi.
//  Revision : 1.0 - initial release
// ============================================================================
module flash_access_ctrl #(
   parameter int SYNC_STAGES    = 2,
   parameter int TURNAROUND     = 4,
   parameter int CS_GUARD       = 8,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic CLK,
   input  logic RESET,
   input  logic PI_REQ,
   input  logic PI_CS,
   input  logic PI_SCK,
   output logic PI_ACK,
   output logic PI_OE,
   input  logic FPGA_FLASH_BUSY,
   output logic FPGA_FLASH_HOLD,
   output logic REVOKED
);

   // One shared counter serves turnaround, drain guard and inactivity timing;
   // it is sized for the largest of the three.
   localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int TA_W  = $clog2(TURNAROUND + 1);
   localparam int CG_W  = $clog2(CS_GUARD + 1);
   localparam int M_W   = (TA_W > CG_W) ? TA_W : CG_W;
   localparam int CNT_W = (TO_W > M_W) ? TO_W : M_W;

   localparam logic [CNT_W-1:0] TA_LAST  = CNT_W'(TURNAROUND - 1);
   localparam logic [CNT_W-1:0] CG_LAST  = CNT_W'(CS_GUARD - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   generate
      if (SYNC_STAGES < 2) begin : g_sync_check
         $error("flash_access_ctrl: SYNC_STAGES must be at least 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_HOLD_WAIT = 3'd1,
      S_GUARD_IN  = 3'd2,
      S_GRANTED   = 3'd3,
      S_DRAIN     = 3'd4,
      S_GUARD_OUT = 3'd5,
      S_LOCKOUT   = 3'd6
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [SYNC_STAGES-1:0] req_sync_q, cs_sync_q, sck_sync_q;
   logic                   sck_prev_q;
   logic                   revoke_d;
   logic                   req_s, cs_s, sck_s, sck_edge;

   assign req_s    = req_sync_q[SYNC_STAGES-1];
   assign cs_s     = cs_sync_q[SYNC_STAGES-1];
   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign sck_edge = sck_s ^ sck_prev_q;

   // Synchronise the Pi inputs; CS idles high so its chain resets to 1.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         req_sync_q <= '0;
         cs_sync_q  <= '1;
         sck_sync_q <= '0;
         sck_prev_q <= 1'b0;
      end else begin
         req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], PI_REQ};
         cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], PI_CS};
         sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], PI_SCK};
         sck_prev_q <= sck_s;
      end
   end

   // Next-state and counter logic for the grant sequence.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      revoke_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_s) state_d = S_HOLD_WAIT;
         end
         S_HOLD_WAIT: begin
            if (!req_s) begin
               state_d = S_IDLE;
            end else if (!FPGA_FLASH_BUSY) begin
               state_d = S_GUARD_IN;
               cnt_d   = CNT_ZERO;
            end
         end
         S_GUARD_IN: begin
            if (!req_s) begin
               state_d = S_IDLE;
            end else if (cnt_q == TA_LAST) begin
               state_d = S_GRANTED;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_GRANTED: begin
            // A voluntary release takes priority over a coincident timeout.
            if (!req_s) begin
               state_d = S_DRAIN;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == TO_LAST) begin
               state_d  = S_DRAIN;
               cnt_d    = CNT_ZERO;
               revoke_d = 1'b1;
            end else if (!cs_s || sck_edge) begin
               cnt_d = CNT_ZERO;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_DRAIN: begin
            // Only a run of CS_GUARD idle-high CS cycles lets the Pi go.
            if (!cs_s) begin
               cnt_d = CNT_ZERO;
            end else if (cnt_q == CG_LAST) begin
               state_d = S_GUARD_OUT;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_GUARD_OUT: begin
            if (cnt_q == TA_LAST) begin
               state_d = S_LOCKOUT;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_LOCKOUT: begin
            if (!req_s) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // State, counter and registered outputs decoded from the next state.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q         <= S_IDLE;
         cnt_q           <= CNT_ZERO;
         PI_ACK          <= 1'b0;
         PI_OE           <= 1'b0;
         FPGA_FLASH_HOLD <= 1'b0;
         REVOKED         <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         PI_ACK          <= (state_d == S_GRANTED);
         PI_OE           <= (state_d == S_GRANTED) || (state_d == S_DRAIN);
         FPGA_FLASH_HOLD <= (state_d == S_HOLD_WAIT) || (state_d == S_GUARD_IN) ||
                            (state_d == S_GRANTED)   || (state_d == S_DRAIN)    ||
                            (state_d == S_GUARD_OUT);
         REVOKED         <= revoke_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_flash_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flash_access_ctrl
//  Purpose  : Directed self-checking bench for flash_access_ctrl
//  Revision : 1.0 - initial release
// ============================================================================
module tb_flash_access_ctrl;

   logic CLK, RESET, PI_REQ, PI_CS, PI_SCK, FPGA_FLASH_BUSY;
   logic PI_ACK, PI_OE, FPGA_FLASH_HOLD, REVOKED;

   int checks = 0;
   int errors = 0;

   flash_access_ctrl #(
      .SYNC_STAGES(2), .TURNAROUND(4), .CS_GUARD(8), .TIMEOUT_CYCLES(64)
   ) dut (
      .CLK(CLK), .RESET(RESET), .PI_REQ(PI_REQ), .PI_CS(PI_CS), .PI_SCK(PI_SCK),
      .PI_ACK(PI_ACK), .PI_OE(PI_OE), .FPGA_FLASH_BUSY(FPGA_FLASH_BUSY),
      .FPGA_FLASH_HOLD(FPGA_FLASH_HOLD), .REVOKED(REVOKED)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // PI_OE must never be high without FPGA_FLASH_HOLD.
   always @(negedge CLK) begin
      if (!RESET) begin
         checks++;
         if (PI_OE && !FPGA_FLASH_HOLD) begin
            errors++;
            $display("FAIL invariant_oe_hold t=%0t oe=%b hold=%b required hold=1", $time, PI_OE, FPGA_FLASH_HOLD);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RESET = 1'b1; PI_REQ = 1'b0; PI_CS = 1'b1; PI_SCK = 1'b0; FPGA_FLASH_BUSY = 1'b0;
      tick(); tick();
      checks++;
      if ({PI_ACK, PI_OE, FPGA_FLASH_HOLD, REVOKED} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs got %b required 0000", {PI_ACK, PI_OE, FPGA_FLASH_HOLD, REVOKED});
      end
      RESET = 1'b0;
      repeat (4) tick();
      checks++;
      if ({PI_ACK, PI_OE, FPGA_FLASH_HOLD, REVOKED} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_idle got %b required 0000", {PI_ACK, PI_OE, FPGA_FLASH_HOLD, REVOKED});
      end
   endtask

   task automatic test_basic_grant();
      PI_REQ = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         tick();
         checks++;
         if (FPGA_FLASH_HOLD !== (e >= 3)) begin
            errors++;
            $display("FAIL basic_hold edge=%0d got %b required %b", e, FPGA_FLASH_HOLD, (e >= 3));
         end
         checks++;
         if ({PI_OE, PI_ACK} !== {2{e >= 8}}) begin
            errors++;
            $display("FAIL basic_oe_ack edge=%0d got %b required %b", e, {PI_OE, PI_ACK}, {2{e >= 8}});
         end
      end
      PI_REQ = 1'b0;
      for (int e = 1; e <= 17; e++) begin
         tick();
         checks++;
         if (PI_ACK !== (e < 3)) begin
            errors++;
            $display("FAIL release_ack edge=%0d got %b required %b", e, PI_ACK, (e < 3));
         end
         checks++;
         if (PI_OE !== (e < 11)) begin
            errors++;
            $display("FAIL release_oe edge=%0d got %b required %b", e, PI_OE, (e < 11));
         end
         checks++;
         if (FPGA_FLASH_HOLD !== (e < 15)) begin
            errors++;
            $display("FAIL release_hold edge=%0d got %b required %b", e, FPGA_FLASH_HOLD, (e < 15));
         end
      end
   endtask

   task automatic test_busy_deferral();
      FPGA_FLASH_BUSY = 1'b1;
      PI_REQ = 1'b1;
      for (int e = 1; e <= 23; e++) begin
         tick();
         checks++;
         if ({FPGA_FLASH_HOLD, PI_OE} !== {(e >= 3), 1'b0}) begin
            errors++;
            $display("FAIL busy_wait edge=%0d hold,oe got %b required %b", e, {FPGA_FLASH_HOLD, PI_OE}, {(e >= 3), 1'b0});
         end
      end
      FPGA_FLASH_BUSY = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         tick();
         checks++;
         if ({PI_OE, PI_ACK} !== {2{e >= 5}}) begin
            errors++;
            $display("FAIL busy_release edge=%0d oe,ack got %b required %b", e, {PI_OE, PI_ACK}, {2{e >= 5}});
         end
      end
      PI_REQ = 1'b0;
      repeat (20) tick();
      checks++;
      if ({FPGA_FLASH_HOLD, PI_OE, PI_ACK} !== 3'b000) begin
         errors++;
         $display("FAIL busy_end got %b required 000", {FPGA_FLASH_HOLD, PI_OE, PI_ACK});
      end
   endtask

   task automatic test_drain_protection();
      PI_REQ = 1'b1;
      repeat (8) tick();
      checks++;
      if (PI_OE !== 1'b1) begin
         errors++;
         $display("FAIL drain_granted got %b required 1", PI_OE);
      end
      PI_CS = 1'b0;
      PI_REQ = 1'b0;
      for (int e = 1; e <= 30; e++) begin
         tick();
         checks++;
         if ({PI_OE, PI_ACK} !== {1'b1, (e < 3)}) begin
            errors++;
            $display("FAIL drain_cs_low edge=%0d oe,ack got %b required %b", e, {PI_OE, PI_ACK}, {1'b1, (e < 3)});
         end
      end
      PI_CS = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         tick();
         checks++;
         if (PI_OE !== 1'b1) begin
            errors++;
            $display("FAIL drain_count edge=%0d got %b required 1", e, PI_OE);
         end
      end
      PI_CS = 1'b0;
      tick();
      PI_CS = 1'b1;
      for (int e = 1; e <= 15; e++) begin
         tick();
         checks++;
         if (PI_OE !== (e < 10)) begin
            errors++;
            $display("FAIL drain_restart_oe edge=%0d got %b required %b", e, PI_OE, (e < 10));
         end
         checks++;
         if (FPGA_FLASH_HOLD !== (e < 14)) begin
            errors++;
            $display("FAIL drain_restart_hold edge=%0d got %b required %b", e, FPGA_FLASH_HOLD, (e < 14));
         end
      end
      repeat (3) tick();
   endtask

   task automatic test_timeout();
      PI_REQ = 1'b1;
      repeat (8) tick();
      checks++;
      if (PI_OE !== 1'b1) begin
         errors++;
         $display("FAIL timeout_granted got %b required 1", PI_OE);
      end
      for (int e = 1; e <= 80; e++) begin
         tick();
         checks++;
         if (REVOKED !== (e == 64)) begin
            errors++;
            $display("FAIL timeout_revoked edge=%0d got %b required %b", e, REVOKED, (e == 64));
         end
         checks++;
         if ({PI_ACK, PI_OE, FPGA_FLASH_HOLD} !== {(e < 64), (e < 72), (e < 76)}) begin
            errors++;
            $display("FAIL timeout_seq edge=%0d ack,oe,hold got %b required %b", e,
                     {PI_ACK, PI_OE, FPGA_FLASH_HOLD}, {(e < 64), (e < 72), (e < 76)});
         end
      end
      for (int e = 1; e <= 20; e++) begin
         tick();
         checks++;
         if ({FPGA_FLASH_HOLD, PI_OE, PI_ACK} !== 3'b000) begin
            errors++;
            $display("FAIL lockout edge=%0d got %b required 000", e, {FPGA_FLASH_HOLD, PI_OE, PI_ACK});
         end
      end
      PI_REQ = 1'b0;
      repeat (5) tick();
      PI_REQ = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         checks++;
         if ({FPGA_FLASH_HOLD, PI_OE} !== {(e >= 3), (e >= 8)}) begin
            errors++;
            $display("FAIL regrant edge=%0d hold,oe got %b required %b", e, {FPGA_FLASH_HOLD, PI_OE}, {(e >= 3), (e >= 8)});
         end
      end
      PI_REQ = 1'b0;
      repeat (20) tick();
   endtask

   task automatic test_activity();
      PI_REQ = 1'b1;
      repeat (8) tick();
      for (int c = 0; c < 1000; c++) begin
         tick();
         checks++;
         if ({PI_OE, REVOKED} !== 2'b10) begin
            errors++;
            $display("FAIL activity cycle=%0d oe,revoked got %b required 10", c, {PI_OE, REVOKED});
         end
         if ((c % 40) == 39) PI_SCK = ~PI_SCK;
      end
      PI_REQ = 1'b0;
      repeat (20) tick();
      checks++;
      if ({FPGA_FLASH_HOLD, PI_OE} !== 2'b00) begin
         errors++;
         $display("FAIL activity_end got %b required 00", {FPGA_FLASH_HOLD, PI_OE});
      end
   endtask

   task automatic test_reset_mid_grant();
      PI_REQ = 1'b1;
      repeat (10) tick();
      checks++;
      if (PI_OE !== 1'b1) begin
         errors++;
         $display("FAIL rst_grant got %b required 1", PI_OE);
      end
      #2 RESET = 1'b1;
      #1;
      checks++;
      if ({PI_OE, FPGA_FLASH_HOLD, PI_ACK} !== 3'b000) begin
         errors++;
         $display("FAIL rst_async got %b required 000", {PI_OE, FPGA_FLASH_HOLD, PI_ACK});
      end
      tick();
      RESET = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         tick();
         checks++;
         if ({FPGA_FLASH_HOLD, PI_OE, PI_ACK} !== {(e >= 3), {2{e >= 8}}}) begin
            errors++;
            $display("FAIL rst_regrant edge=%0d got %b required %b", e,
                     {FPGA_FLASH_HOLD, PI_OE, PI_ACK}, {(e >= 3), {2{e >= 8}}});
         end
      end
      PI_REQ = 1'b0;
      repeat (20) tick();
   endtask

   initial begin
      test_reset();
      test_basic_grant();
      test_busy_deferral();
      test_drain_protection();
      test_timeout();
      test_activity();
      test_reset_mid_grant();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/flash_access_ctrl.md
Name: flash_access_ctrl

Overview:
- Clocked arbiter that decides when the Raspberry Pi may drive the shared SPI configuration flash.
- Its PI_OE output feeds the flash pass-through stage, which enables the Pi's CS/SCK/MOSI drivers onto the flash pins.
- Handshakes with the internal FPGA flash master: that master is held off before the Pi gets the bus, and is held off again for a turnaround after the Pi releases it.
- Revokes the grant if the Pi goes silent.

Parameters:
SYNC_STAGES, 2, flops in each asynchronous-input synchroniser (minimum 2)
TURNAROUND, 4, CLK cycles with no driver enabled, both before and after a Pi grant
CS_GUARD, 8, consecutive CLK cycles cs_s must be high before PI_OE may drop
TIMEOUT_CYCLES, 1000000, inactivity cycles in GRANTED before forced revoke; counter width = clog2(TIMEOUT_CYCLES)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
PI_REQ  in  1  Pi flash-access request, asynchronous, level
PI_CS  in  1  Pi flash chip select, active-low, asynchronous
PI_SCK  in  1  Pi SPI clock, asynchronous
PI_ACK  out  1  grant indication to the Pi
PI_OE  out  1  enable for the Pi-to-flash pass-through stage
FPGA_FLASH_BUSY  in  1  internal flash master transaction in progress (CLK domain)
FPGA_FLASH_HOLD  out  1  internal master must not start a transaction while high
REVOKED  out  1  one-cycle pulse when the grant is removed by timeout

Behaviour:
- Clock/reset: one clock, CLK. RESET is asynchronous and active-high.
- Reset values: state IDLE; PI_ACK, PI_OE, FPGA_FLASH_HOLD and REVOKED all 0; counters 0; synchronisers 0 except the PI_CS chain, which resets to 1.
- Reset asserted mid-grant drops PI_OE asynchronously. There is no guard in that case.
- Synchronisers: PI_REQ, PI_CS and PI_SCK each pass through SYNC_STAGES flops, giving req_s, cs_s and sck_s.
- sck_edge = sck_s XOR its previous value.
- All outputs are registered and decoded from the next state.
- IDLE: all outputs 0. If req_s=1, go to HOLD_WAIT.
- HOLD_WAIT: HOLD=1.
  - req_s=0 -> IDLE.
  - Otherwise, once FPGA_FLASH_BUSY=0 is sampled, go to GUARD_IN with the counter loaded to 0. BUSY may still be high in the first HOLD cycle; wait until it clears.
- GUARD_IN: HOLD=1, PI_OE=0. Count TURNAROUND cycles, then go to GRANTED.
  - req_s=0 -> IDLE.
- GRANTED: HOLD=1, PI_OE=1, PI_ACK=1.
  - Inactivity counter clears when cs_s=0 or sck_edge=1; otherwise it increments.
  - req_s=0 -> DRAIN.
  - Else if counter = TIMEOUT_CYCLES-1 -> DRAIN, and REVOKED=1 for exactly 1 cycle.
  - If req_s falls in the same cycle as the timeout, the release wins and REVOKED stays 0.
- DRAIN: PI_ACK=0, PI_OE=1, HOLD=1.
  - Guard counter counts consecutive cs_s=1 cycles; it resets whenever cs_s=0.
  - After CS_GUARD consecutive high cycles, go to GUARD_OUT. A transaction in flight is never cut.
  - req_s re-rising in DRAIN is ignored.
- GUARD_OUT: PI_OE=0, HOLD=1 for TURNAROUND cycles, then LOCKOUT.
- LOCKOUT: HOLD=0, all outputs 0. Stay until req_s=0, then go to IDLE. A fresh request edge is required after every grant.
- Latency: PI_REQ rise to FPGA_FLASH_HOLD rise is SYNC_STAGES+1 CLK edges. With BUSY=0, PI_OE rises TURNAROUND+1 edges after HOLD.
- Invariant: PI_OE=1 implies FPGA_FLASH_HOLD=1 in every cycle.

Test Plan:
Bench parameters: SYNC_STAGES=2, TURNAROUND=4, CS_GUARD=8, TIMEOUT_CYCLES=64.
1. Basic grant: FPGA_FLASH_BUSY=0, PI_REQ 0->1 -> HOLD high at edge 3, PI_OE and PI_ACK high at edge 8. Drop PI_REQ with PI_CS=1 -> PI_ACK low at edge 3, PI_OE low 8 cycles later, HOLD low 4 cycles after PI_OE.
2. Busy deferral: hold FPGA_FLASH_BUSY=1 for 20 cycles after HOLD rises -> PI_OE stays 0 throughout, and rises 5 edges after BUSY falls.
3. Drain protection: drop PI_REQ while PI_CS=0 for 30 more cycles -> PI_OE stays 1 until 8 cycles after cs_s returns high. Pulse PI_CS low again at drain count 5 -> count restarts.
4. Timeout: grant held, PI_CS=1, PI_SCK static -> REVOKED pulses 1 cycle at inactivity count 63, then drain/guard proceed. New grant only after PI_REQ goes 0 then 1.
5. Activity keeps the grant: toggle PI_SCK every 40 cycles for 1000 cycles -> no REVOKED, PI_OE continuously 1.
6. Reset mid-grant: assert RESET while PI_OE=1 -> PI_OE, HOLD and PI_ACK go 0 without waiting for CLK. After release with PI_REQ still 1 -> a normal grant sequence repeats.
